// File: rtl/uart_ts_pkg.sv
// Shared definitions for the UART timestamp frame scheduler: FSM states,
// default sync byte and the fixed per-frame byte overhead.
package uart_ts_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   // Sync byte + tag byte + checksum byte around the timestamp bytes.
   localparam int FRAME_OVERHEAD = 3;

endpackage

// File: rtl/uart_ts_rr_arb2.sv
// Two-way round-robin arbiter. The last-grant register moves only when the
// caller signals that the granted request was actually accepted.
module uart_ts_rr_arb2 (
   input  logic clk,
   input  logic rst_n,
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_update,
   output logic o_grant,
   output logic o_grant_valid
);

   logic r_last_grant;

   always_comb begin
      o_grant_valid = i_valid0 | i_valid1;
      // On a tie favour whoever did not win last time.
      if (i_valid0 && i_valid1) begin
         o_grant = ~r_last_grant;
      end else begin
         o_grant = i_valid1;
      end
   end

   // Reset to requester 1 so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= 1'b1;
      end else if (i_update && o_grant_valid) begin
         r_last_grant <= o_grant;
      end
   end

endmodule

// File: rtl/uart_ts_scheduler.sv
// Arbitrates two timestamp requesters and serialises each accepted record as
// a framed byte stream: sync, {src,tag}, timestamp MSB first, XOR checksum.
module uart_ts_scheduler
   import uart_ts_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
   parameter int         TS_W      = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   input  logic [6:0]      req0_tag,
   input  logic [TS_W-1:0] req0_ts,
   output logic            req0_ready,
   input  logic            req1_valid,
   input  logic [6:0]      req1_tag,
   input  logic [TS_W-1:0] req1_ts,
   output logic            req1_ready,
   output logic            tx_valid,
   output logic [7:0]      tx_data,
   input  logic            tx_ready,
   output logic            busy,
   output logic [15:0]     frames_sent
);

   localparam int NB     = TS_W / 8;
   localparam int NBYTES = NB + FRAME_OVERHEAD;
   localparam int IDX_W  = $clog2(NBYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

   state_t            r_state;
   state_t            w_state_next;
   logic [IDX_W-1:0]  r_idx;
   logic              r_src;
   logic [6:0]        r_tag;
   logic [TS_W-1:0]   r_ts;
   logic [7:0]        r_csum;
   logic [15:0]       r_frames_cnt;

   logic              w_idle;
   logic              w_grant;
   logic              w_grant_valid;
   logic              w_accept;
   logic              w_xfer;
   logic              w_last;
   logic [6:0]        w_sel_tag;
   logic [TS_W-1:0]   w_sel_ts;
   logic [7:0]        w_tag_byte;
   logic [7:0]        w_csum;
   logic [7:0]        w_frame_byte [0:NBYTES-1];

   uart_ts_rr_arb2 u_arb (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_valid0     (req0_valid),
      .i_valid1     (req1_valid),
      .i_update     (w_accept),
      .o_grant      (w_grant),
      .o_grant_valid(w_grant_valid)
   );

   assign w_idle     = (r_state == IDLE);
   // Readies are gated with rst_n so they read low while reset is held.
   assign req0_ready = rst_n && w_idle && w_grant_valid && !w_grant;
   assign req1_ready = rst_n && w_idle && w_grant_valid && w_grant;
   assign w_accept   = req0_ready | req1_ready;
   assign w_xfer     = !w_idle && tx_ready;
   assign w_last     = (r_idx == LAST_IDX);

   assign w_sel_tag  = w_grant ? req1_tag : req0_tag;
   assign w_sel_ts   = w_grant ? req1_ts  : req0_ts;
   assign w_tag_byte = {w_grant, w_sel_tag};

   // Checksum is fixed at acceptance, so it is ready long before the last byte.
   always_comb begin
      w_csum = w_tag_byte;
      for (int k = 0; k < NB; k++) begin
         w_csum = w_csum ^ w_sel_ts[8*k +: 8];
      end
   end

   assign w_frame_byte[0]        = SYNC_BYTE;
   assign w_frame_byte[1]        = {r_src, r_tag};
   assign w_frame_byte[NBYTES-1] = r_csum;

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_ts_bytes
         assign w_frame_byte[gi+2] = r_ts[TS_W-1-8*gi -: 8];
      end
   endgenerate

   assign tx_valid    = !w_idle;
   assign busy        = !w_idle;
   assign tx_data     = w_idle ? 8'h00 : w_frame_byte[r_idx];
   assign frames_sent = r_frames_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: if (w_accept)          w_state_next = SEND;
         SEND: if (w_xfer && w_last)  w_state_next = IDLE;
         default:                     w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx        <= '0;
         r_src        <= 1'b0;
         r_tag        <= '0;
         r_ts         <= '0;
         r_csum       <= '0;
         r_frames_cnt <= '0;
      end else if (w_accept) begin
         r_idx  <= '0;
         r_src  <= w_grant;
         r_tag  <= w_sel_tag;
         r_ts   <= w_sel_ts;
         r_csum <= w_csum;
      end else if (w_xfer) begin
         if (w_last) begin
            r_idx        <= '0;
            r_frames_cnt <= r_frames_cnt + 16'd1;
         end else begin
            r_idx <= r_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_ts_scheduler.sv
// Directed bench for uart_ts_scheduler: frames, round-robin tie, backpressure,
// input isolation, mid-frame reset and frame-counter wrap.
module tb_uart_ts_scheduler;

   logic        clk;
   logic        rst_n;
   logic        req0_valid;
   logic [6:0]  req0_tag;
   logic [63:0] req0_ts;
   logic        req0_ready;
   logic        req1_valid;
   logic [6:0]  req1_tag;
   logic [63:0] req1_ts;
   logic        req1_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic        busy;
   logic [15:0] frames_sent;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   logic [7:0]  q  [$];
   int          qc [$];
   logic [7:0]  exp_f [0:10];

   uart_ts_scheduler dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_tag   (req0_tag),
      .req0_ts    (req0_ts),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_tag   (req1_tag),
      .req1_ts    (req1_ts),
      .req1_ready (req1_ready),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .busy       (busy),
      .frames_sent(frames_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Byte monitor: a byte seen valid&&ready at the negedge transfers on the next posedge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst_n && tx_valid && tx_ready) begin
         q.push_back(tx_data);
         qc.push_back(cyc);
      end
   end

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", name, obs, expv);
      end
   endtask

   task automatic wait_bytes(input int n);
      int k = 0;
      while (q.size() < n && k < 300) begin
         @(negedge clk);
         k++;
      end
      chk("byte_count", 64'(q.size()), 64'(n));
   endtask

   task automatic check_frame(input int off, input string name);
      for (int i = 0; i < 11; i++) begin
         if (off + i < q.size())
            chk($sformatf("%s_byte%0d", name, i), 64'(q[off+i]), 64'(exp_f[i]));
         else
            chk($sformatf("%s_byte%0d_missing", name, i), 64'(0), 64'(1));
      end
   endtask

   task automatic send_req0(input logic [6:0] tag, input logic [63:0] ts);
      @(posedge clk); #1;
      req0_valid = 1'b1;
      req0_tag   = tag;
      req0_ts    = ts;
      @(negedge clk);
      chk("req0_ready_offer", 64'(req0_ready), 64'(1));
      @(posedge clk); #1;
      req0_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      rst_n      = 1'b0;
      req0_valid = 1'b1;
      req0_tag   = '0;
      req0_ts    = '0;
      req1_valid = 1'b0;
      req1_tag   = '0;
      req1_ts    = '0;
      tx_ready   = 1'b1;

      // Reset state, with a request already offered.
      #12;
      chk("rst_tx_valid", 64'(tx_valid), 64'(0));
      chk("rst_tx_data", 64'(tx_data), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_frames", 64'(frames_sent), 64'(0));
      chk("rst_req0_ready", 64'(req0_ready), 64'(0));
      chk("rst_req1_ready", 64'(req1_ready), 64'(0));
      req0_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Tie right after reset: req0 first, then req1, one idle cycle between.
      q.delete(); qc.delete();
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_tag = 7'h02; req0_ts = 64'h11;
      req1_valid = 1'b1; req1_tag = 7'h01; req1_ts = 64'h0123_4567_89AB_CDEF;
      @(negedge clk);
      chk("tie_req0_ready", 64'(req0_ready), 64'(1));
      chk("tie_req1_ready", 64'(req1_ready), 64'(0));
      @(posedge clk); #1;
      req0_valid = 1'b0;
      @(negedge clk);
      chk("tie_busy", 64'(busy), 64'(1));
      chk("tie_send_req1_ready", 64'(req1_ready), 64'(0));
      k = 0;
      while (!req1_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("tie_req1_granted", 64'(req1_ready), 64'(1));
      @(posedge clk); #1;
      req1_valid = 1'b0;
      wait_bytes(22);
      exp_f = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h13};
      check_frame(0, "tie_f0");
      exp_f = '{8'hA5, 8'h81, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF, 8'h81};
      check_frame(11, "tie_f1");
      if (qc.size() >= 12) chk("tie_gap", 64'(qc[11] - qc[10]), 64'(2));
      else                 chk("tie_gap_missing", 64'(0), 64'(1));
      @(posedge clk); @(negedge clk);
      chk("tie_frames", 64'(frames_sent), 64'(2));
      chk("tie_idle_valid", 64'(tx_valid), 64'(0));

      // Basic single-requester frame.
      q.delete(); qc.delete();
      send_req0(7'h01, 64'h0000_0000_0000_00FF);
      wait_bytes(11);
      exp_f = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFE};
      check_frame(0, "basic");
      @(posedge clk); @(negedge clk);
      chk("basic_frames", 64'(frames_sent), 64'(3));
      chk("basic_busy_low", 64'(busy), 64'(0));

      // Backpressure on byte index 3 for five cycles.
      q.delete(); qc.delete();
      send_req0(7'h05, 64'h0000_0000_0000_1234);
      repeat (3) @(posedge clk);
      #1 tx_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("bp_valid", 64'(tx_valid), 64'(1));
         chk("bp_data", 64'(tx_data), 64'(8'h00));
         chk("bp_busy", 64'(busy), 64'(1));
      end
      chk("bp_count_stalled", 64'(q.size()), 64'(3));
      @(posedge clk); #1;
      tx_ready = 1'b1;
      wait_bytes(11);
      exp_f = '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h23};
      check_frame(0, "bp");
      @(posedge clk); @(negedge clk);
      chk("bp_frames", 64'(frames_sent), 64'(4));

      // Request inputs change after acceptance; the frame keeps the captured record.
      q.delete(); qc.delete();
      send_req0(7'h03, 64'h0102_0304_0506_0708);
      req0_ts  = 64'hFFFF_FFFF_FFFF_FFFF;
      req0_tag = 7'h7F;
      wait_bytes(11);
      exp_f = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h0B};
      check_frame(0, "hold");
      @(posedge clk); @(negedge clk);
      chk("hold_frames", 64'(frames_sent), 64'(5));

      // Reset during byte index 6 aborts the frame.
      q.delete(); qc.delete();
      send_req0(7'h04, 64'hAAAA_BBBB_CCCC_DDDD);
      repeat (6) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(tx_valid), 64'(0));
      chk("mid_rst_frames", 64'(frames_sent), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_data", 64'(tx_data), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", 64'(tx_valid), 64'(0));
      q.delete(); qc.delete();
      send_req0(7'h7F, 64'hDEAD_BEEF_0000_0001);
      wait_bytes(11);
      exp_f = '{8'hA5, 8'h7F, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h5C};
      check_frame(0, "post_rst");
      @(posedge clk); @(negedge clk);
      chk("post_rst_frames", 64'(frames_sent), 64'(1));

      // Frame counter wrap from 16'hFFFF.
      @(negedge clk);
      force dut.r_frames_cnt = 16'hFFFF;
      @(negedge clk);
      release dut.r_frames_cnt;
      @(negedge clk);
      chk("wrap_preload", 64'(frames_sent), 64'(16'hFFFF));
      q.delete(); qc.delete();
      send_req0(7'h01, 64'h0000_0000_0000_00FF);
      wait_bytes(11);
      @(posedge clk); @(negedge clk);
      chk("wrap_frames", 64'(frames_sent), 64'(0));
      chk("wrap_busy_low", 64'(busy), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
